// File: rtl/atm_pkg.sv
// Shared definitions for the atm keypad frontend and the atm core.
// The contents are key codes, operation encodings, the frontend state enum and a digit test.
package atm_pkg;

    // Keypad codes 0-9 are digits. The function keys use the codes below.
    localparam logic [3:0] KEY_ENTER    = 4'hA;
    localparam logic [3:0] KEY_CLEAR    = 4'hB;
    localparam logic [3:0] KEY_CANCEL   = 4'hC;
    localparam logic [3:0] KEY_BALANCE  = 4'hD;
    localparam logic [3:0] KEY_DEPOSIT  = 4'hE;
    localparam logic [3:0] KEY_WITHDRAW = 4'hF;

    // Operation encodings. The atm core uses the same values.
    localparam logic [1:0] OP_BAL = 2'b00;
    localparam logic [1:0] OP_DEP = 2'b01;
    localparam logic [1:0] OP_WDR = 2'b10;

    localparam int AMT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PIN,
        ST_CHECK,
        ST_OPSEL,
        ST_AMT,
        ST_ISSUE,
        ST_WAIT,
        ST_LOCK
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/atm_keypad_frontend_if.sv
// Interface between the keypad frontend, the keypad and the atm core.
//   master : the frontend. It samples key, pin, unlock and ack signals.
//            It drives pin, operation, amount, txn_req, busy and locked.
//   slave  : the environment, meaning the keypad, the operator and the atm core.
interface atm_keypad_frontend_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [3:0]  correct_pin;
    logic        unlock;
    logic        txn_ack;
    logic [3:0]  pin;
    logic [1:0]  operation;
    logic [15:0] amount;
    logic        txn_req;
    logic        busy;
    logic        locked;

    modport master (
        input  key_valid, key_code, correct_pin, unlock, txn_ack,
        output pin, operation, amount, txn_req, busy, locked
    );

    modport slave (
        output key_valid, key_code, correct_pin, unlock, txn_ack,
        input  pin, operation, amount, txn_req, busy, locked
    );
endinterface

// File: rtl/atm_bcd_accum.sv
// Decimal amount accumulator. Each accepted digit computes acc = acc*10 + digit.
// Digits beyond AMT_DIGITS are dropped. clr has priority over push.
//   clk, reset : clock and async active-high reset
//   clr        : zero the amount and the digit count
//   push       : digit is valid this cycle
//   digit      : 0..9
//   acc        : binary amount
module atm_bcd_accum
    import atm_pkg::*;
#(
    parameter int AMT_DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic [3:0]       digit,
    output logic [AMT_W-1:0] acc
);
    localparam logic [2:0] NDIG_MAX = 3'(AMT_DIGITS);

    logic [2:0]       ndig;
    logic [AMT_W-1:0] times10;

    // Compute acc*10 as (acc<<3) + (acc<<1). The digit limit keeps this within 16 bits.
    assign times10 = {acc[AMT_W-4:0], 3'b000} + {acc[AMT_W-2:0], 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            ndig <= '0;
        end else if (clr) begin
            acc  <= '0;
            ndig <= '0;
        end else if (push && (ndig < NDIG_MAX)) begin
            acc  <= times10 + {{(AMT_W-4){1'b0}}, digit};
            ndig <= ndig + 3'd1;
        end
    end
endmodule

// File: rtl/atm_keypad_frontend.sv
// Keypad frontend of the atm. It turns a key stream into one transaction request.
// It checks a 1-digit PIN, selects the operation and collects a decimal amount.
// It then pulses txn_req and waits for txn_ack. Wrong PINs are counted and lead to lockout.
//   clk, reset : clock and async active-high reset
//   bus        : master side of atm_keypad_frontend_if, carrying keys, PIN, unlock,
//                the request/ack handshake and the status flags
module atm_keypad_frontend
    import atm_pkg::*;
#(
    parameter int MAX_TRIES   = 3,
    parameter int AMT_DIGITS  = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    atm_keypad_frontend_if.master  bus
);
    localparam int               TMR_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]       TRIES_MAX = 3'(MAX_TRIES);

    state_t           state_q, state_d;
    logic [3:0]       pin_q, pin_d;
    logic [2:0]       tries_q, tries_d;
    logic [1:0]       op_q, op_d;          // operation chosen in OPSEL
    logic [TMR_W-1:0] timer_q;
    logic [3:0]       out_pin_q;
    logic [1:0]       out_op_q;
    logic [AMT_W-1:0] out_amt_q;
    logic [AMT_W-1:0] acc;
    logic             acc_clr, acc_push;
    logic             kv, kdig, timed, expired;
    logic [3:0]       k;

    assign kv   = bus.key_valid;
    assign k    = bus.key_code;
    assign kdig = kv && is_digit(k);

    // The timer runs only in the states that wait on a person or on the core.
    assign timed   = (state_q == ST_PIN) || (state_q == ST_OPSEL) ||
                     (state_q == ST_AMT) || (state_q == ST_WAIT);
    // A key arriving in the last cycle still counts as activity.
    assign expired = timed && !kv && (timer_q == TMR_LAST);

    atm_bcd_accum #(.AMT_DIGITS(AMT_DIGITS)) u_accum (
        .clk   (clk),
        .reset (reset),
        .clr   (acc_clr),
        .push  (acc_push),
        .digit (k),
        .acc   (acc)
    );

    always_comb begin
        state_d  = state_q;
        pin_d    = pin_q;
        tries_d  = tries_q;
        op_d     = op_q;
        acc_clr  = 1'b0;
        acc_push = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (kdig) begin
                    pin_d   = k;
                    state_d = ST_PIN;
                end
            end
            ST_PIN: begin
                if (kdig) begin
                    pin_d = k;
                end else if (kv && k == KEY_CLEAR) begin
                    pin_d = 4'd0;
                end else if (kv && k == KEY_ENTER) begin
                    state_d = ST_CHECK;
                end else if (kv && k == KEY_CANCEL) begin
                    pin_d   = 4'd0;
                    acc_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (pin_q == bus.correct_pin) begin
                    tries_d = 3'd0;
                    state_d = ST_OPSEL;
                end else begin
                    tries_d = tries_q + 3'd1;
                    state_d = (tries_q + 3'd1 == TRIES_MAX) ? ST_LOCK : ST_IDLE;
                end
            end
            ST_OPSEL: begin
                if (kv && k == KEY_BALANCE) begin
                    op_d    = OP_BAL;
                    state_d = ST_ISSUE;
                end else if (kv && (k == KEY_DEPOSIT || k == KEY_WITHDRAW)) begin
                    op_d    = (k == KEY_DEPOSIT) ? OP_DEP : OP_WDR;
                    acc_clr = 1'b1;
                    state_d = ST_AMT;
                end else if (kv && k == KEY_CANCEL) begin
                    pin_d   = 4'd0;
                    acc_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_AMT: begin
                if (kdig) begin
                    acc_push = 1'b1;
                end else if (kv && k == KEY_CLEAR) begin
                    acc_clr = 1'b1;
                end else if (kv && k == KEY_ENTER) begin
                    // ENTER with a zero amount is ignored.
                    if (acc != '0) state_d = ST_ISSUE;
                end else if (kv && k == KEY_CANCEL) begin
                    pin_d   = 4'd0;
                    acc_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // The ack takes priority over a key and over the timeout. Keys are dropped here.
                if (bus.txn_ack) state_d = ST_OPSEL;
                else if (expired) state_d = ST_IDLE;
            end
            ST_LOCK: begin
                if (bus.unlock) begin
                    tries_d = 3'd0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pin_q     <= '0;
            tries_q   <= '0;
            op_q      <= OP_BAL;
            timer_q   <= '0;
            out_pin_q <= '0;
            out_op_q  <= OP_BAL;
            out_amt_q <= '0;
        end else begin
            state_q <= state_d;
            pin_q   <= pin_d;
            tries_q <= tries_d;
            op_q    <= op_d;
            if (!timed || kv || state_d != state_q) timer_q <= '0;
            else                                     timer_q <= timer_q + TMR_W'(1);
            // Load the request fields on the edge that enters ISSUE so that they are
            // valid during the txn_req cycle. They hold until the next request.
            if (state_d == ST_ISSUE && state_q != ST_ISSUE) begin
                out_pin_q <= pin_q;
                out_op_q  <= op_d;
                out_amt_q <= (op_d == OP_BAL) ? '0 : acc;
            end
        end
    end

    assign bus.pin       = out_pin_q;
    assign bus.operation = out_op_q;
    assign bus.amount    = out_amt_q;
    assign bus.txn_req   = (state_q == ST_ISSUE);
    assign bus.busy      = (state_q != ST_IDLE) && (state_q != ST_LOCK);
    assign bus.locked    = (state_q == ST_LOCK);
endmodule

// File: tb/tb_atm_keypad_frontend.sv
module tb_atm_keypad_frontend;
    import atm_pkg::*;

    localparam int AMT_DIGITS = 4;

    typedef struct {
        int pin;
        int op;
        int amt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    atm_keypad_frontend_if bus();

    int   checks = 0;
    int   failures = 0;
    int   seen = 0;
    int   pushed = 0;
    exp_t expq[$];
    int   dq[$];
    int   cp;

    atm_keypad_frontend #(.MAX_TRIES(3), .AMT_DIGITS(AMT_DIGITS), .TIMEOUT_CYC(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every txn_req cycle.
    always @(negedge clk) begin
        if (!reset && bus.txn_req === 1'b1) begin
            seen++;
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_txn_req pin=%0d op=%0d amt=%0d", bus.pin, bus.operation, bus.amount);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if (int'(bus.pin) != e.pin || int'(bus.operation) != e.op || int'(bus.amount) != e.amt) begin
                    failures++;
                    $display("FAIL txn_fields actual pin=%0d op=%0d amt=%0d expected pin=%0d op=%0d amt=%0d",
                             bus.pin, bus.operation, bus.amount, e.pin, e.op, e.amt);
                end
            end
        end
    end

    task automatic expect_txn(input int p, input int op, input int amt);
        exp_t e;
        e.pin = p; e.op = op; e.amt = amt;
        expq.push_back(e);
        pushed++;
    endtask

    // Reference for the amount: only the first AMT_DIGITS digits count, read as a decimal number.
    function automatic int model_amount();
        int a = 0;
        int n = (dq.size() < AMT_DIGITS) ? dq.size() : AMT_DIGITS;
        for (int i = 0; i < n; i++) a += dq[i] * (10 ** (n - 1 - i));
        return a;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] c);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic ack();
        bus.txn_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.txn_ack = 1'b0;
    endtask

    task automatic login(input int d);
        key(4'(d));
        key(KEY_ENTER);
        idle(1);
    endtask

    // Select an operation, type the digits in dq, press ENTER and acknowledge the request.
    task automatic do_amount(input logic [3:0] op_key, input int op);
        int a;
        key(op_key);
        foreach (dq[i]) key(4'(dq[i]));
        a = model_amount();
        if (a != 0) expect_txn(cp, op, a);
        key(KEY_ENTER);
        idle(2);
        ack();
    endtask

    initial begin
        int w, start;
        bus.key_valid = 0; bus.key_code = 0; bus.unlock = 0; bus.txn_ack = 0;
        cp = $urandom_range(1, 9);
        bus.correct_pin = 4'(cp);
        idle(3);
        chk("reset_pin", bus.pin, 0);
        chk("reset_op", bus.operation, 0);
        chk("reset_amt", bus.amount, 0);
        chk("reset_txn_req", bus.txn_req, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_locked", bus.locked, 0);
        reset = 1'b0;
        idle(2);

        // PIN entry followed by a balance request. After the ack the session stays in OPSEL.
        login(cp);
        chk("busy_after_login", bus.busy, 1);
        expect_txn(cp, OP_BAL, 0);
        key(KEY_BALANCE);
        idle(2);
        ack();
        chk("busy_after_ack", bus.busy, 1);

        // A deposit of 500 followed by a withdrawal of 300 in the same session.
        dq = '{5, 0, 0};
        do_amount(KEY_DEPOSIT, OP_DEP);
        dq = '{3, 0, 0};
        do_amount(KEY_WITHDRAW, OP_WDR);

        // Five digits are truncated to the first four.
        dq = '{1, 2, 3, 4, 5};
        do_amount(KEY_DEPOSIT, OP_DEP);

        // CLEAR restarts the amount entry.
        key(KEY_DEPOSIT); key(4'd9); key(KEY_CLEAR); key(4'd2);
        expect_txn(cp, OP_DEP, 2);
        key(KEY_ENTER); idle(2); ack();

        // ENTER with no digits must not produce a request.
        start = seen;
        key(KEY_WITHDRAW); key(KEY_ENTER); idle(4);
        chk("empty_enter_no_req", seen - start, 0);
        chk("empty_enter_busy", bus.busy, 1);

        // Random amounts.
        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 6);
            dq.delete();
            dq.push_back($urandom_range(1, 9));
            for (int i = 1; i < n; i++) dq.push_back($urandom_range(0, 9));
            key(KEY_CANCEL);
            login(cp);
            if ($urandom_range(0, 1) == 1) do_amount(KEY_DEPOSIT, OP_DEP);
            else                           do_amount(KEY_WITHDRAW, OP_WDR);
        end
        key(KEY_CANCEL);
        chk("cancel_to_idle", bus.busy, 0);

        // Three wrong PINs cause a lockout. ENTER in IDLE is ignored.
        w = (cp + $urandom_range(1, 9)) % 10;
        for (int t = 0; t < 3; t++) begin
            key(KEY_ENTER);
            login(w);
        end
        chk("locked_after_3", bus.locked, 1);
        login(cp);
        chk("locked_ignores_keys", bus.locked, 1);
        chk("locked_not_busy", bus.busy, 0);
        bus.unlock = 1'b1; idle(1); bus.unlock = 1'b0;
        chk("unlock_clears", bus.locked, 0);
        chk("unlock_idle", bus.busy, 0);
        // After unlock the try counter is zero, so two misses do not lock.
        login(w); login(w);
        chk("tries_reset_not_locked", bus.locked, 0);
        login(cp);
        chk("tries_reset_login_ok", bus.busy, 1);
        key(KEY_CANCEL);

        // Timeout in PIN. The state is still busy after 19 quiet cycles and idle after 20.
        key(4'(cp));
        idle(19);
        chk("pin_timeout_edge_busy", bus.busy, 1);
        idle(1);
        chk("pin_timeout_idle", bus.busy, 0);

        // Timeout in WAIT with no ack. Only one request is issued.
        login(cp);
        start = seen;
        expect_txn(cp, OP_BAL, 0);
        key(KEY_BALANCE);
        idle(20);
        chk("wait_timeout_edge_busy", bus.busy, 1);
        idle(1);
        chk("wait_timeout_idle", bus.busy, 0);
        idle(30);
        chk("wait_timeout_one_req", seen - start, 1);

        // An ack and a key in the same cycle in WAIT: the ack wins and the key is dropped.
        login(cp);
        expect_txn(cp, OP_BAL, 0);
        key(KEY_BALANCE);
        idle(1);
        bus.txn_ack = 1'b1; bus.key_valid = 1'b1; bus.key_code = KEY_DEPOSIT;
        idle(1);
        bus.txn_ack = 1'b0; bus.key_valid = 1'b0;
        chk("ack_key_busy", bus.busy, 1);
        start = seen;
        key(4'd5); key(KEY_ENTER); idle(3);
        chk("ack_key_dropped", seen - start, 0);
        expect_txn(cp, OP_BAL, 0);
        key(KEY_BALANCE); idle(2); ack();
        key(KEY_CANCEL);

        // Reset asserted mid-cycle in AMT clears every output at once.
        login(cp);
        key(KEY_DEPOSIT); key(4'd4); key(4'd2);
        #2 reset = 1'b1;
        #1;
        chk("midreset_pin", bus.pin, 0);
        chk("midreset_op", bus.operation, 0);
        chk("midreset_amt", bus.amount, 0);
        chk("midreset_txn_req", bus.txn_req, 0);
        chk("midreset_busy", bus.busy, 0);
        chk("midreset_locked", bus.locked, 0);
        idle(2);
        reset = 1'b0;
        idle(5);

        chk("scoreboard_drained", expq.size(), 0);
        chk("txn_count", seen, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
